branch_resolve_unit: RTL



---
 rtl/branch_resolve_unit.sv | 63 ++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: MEM-stage branch/jump resolution, PC redirect and 2-bit BHT predictor
module branch_resolve_unit #(
    parameter int BHT_IDX_W = 6
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [31:0] IF_PC,
    output logic        IF_Predict,
    input  logic [1:0]  MEM_Branch,
    input  logic        MEM_Jump,
    input  logic        MEM_jr,
    input  logic        MEM_zero,
    input  logic        MEM_Predict,
    input  logic [31:0] MEM_readData1,
    input  logic [31:0] MEM_NextSeqPC,
    input  logic [31:0] MEM_JumpAddr,
    input  logic [31:0] MEM_BranchAddr,
    output logic        Redirect,
    output logic [31:0] RedirectPC,
    output logic        Flush,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredictCount
);
    logic [1:0] bht [2**BHT_IDX_W];
    logic isBr, taken, mispredict, doUpdate;
    logic [31:0] instPC;
    logic [BHT_IDX_W-1:0] lookIdx, updIdx;
    logic unusedBits;
    // decode the branch kind and derive the BHT indices
    always_comb begin
        isBr = (MEM_Branch == 2'b01) | (MEM_Branch == 2'b10);
        taken = (MEM_Branch == 2'b01 & MEM_zero) | (MEM_Branch == 2'b10 & ~MEM_zero);
        mispredict = isBr & (taken != MEM_Predict);
        doUpdate = isBr & ~MEM_jr & ~MEM_Jump;
        instPC = MEM_NextSeqPC - 32'd4;
        lookIdx = IF_PC[BHT_IDX_W+1:2];
        updIdx = instPC[BHT_IDX_W+1:2];
        unusedBits = &{1'b0, IF_PC[31:BHT_IDX_W+2], IF_PC[1:0], instPC[31:BHT_IDX_W+2], instPC[1:0]};
    end
    // redirect priority jr > j > mispredicted branch; everything held low in reset
    always_comb begin
        Redirect = ~reset & (MEM_jr | MEM_Jump | mispredict);
        RedirectPC = reset ? 32'd0 :
                     MEM_jr ? MEM_readData1 :
                     MEM_Jump ? MEM_JumpAddr :
                     mispredict ? (taken ? MEM_BranchAddr : MEM_NextSeqPC) : 32'd0;
        Flush = Redirect;
        IF_Predict = ~reset & bht[lookIdx][1];
    end
    // train the saturating counters and count resolved/mispredicted branches
    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= 2'b01;
            BranchCount <= 32'd0;
            MispredictCount <= 32'd0;
        end else if (doUpdate) begin
            bht[updIdx] <= taken ? (bht[updIdx] == 2'b11 ? 2'b11 : bht[updIdx] + 2'd1)
                                 : (bht[updIdx] == 2'b00 ? 2'b00 : bht[updIdx] - 2'd1);
            BranchCount <= BranchCount + 32'd1;
            MispredictCount <= MispredictCount + {31'd0, mispredict};
        end
    end
endmodule
